// File: rtl/wb_dcache_flush_ctrl.sv
// wb_dcache_flush_ctrl
// Walks every set of the write-back dcache on a flush request. For each set it
// reads the tag state, writes back every valid+dirty way one at a time, then
// rewrites the set's state bits with dirty cleared. A one-cycle ack ends the flush.
//
// Build option: WB_FLUSH_INVALIDATE_EN
//   defined   -> every line is also invalidated (clr_valid_o = 0)
//   undefined -> lines stay resident (clr_valid_o = valid mask read in WAIT)
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   flush_req_i           flush request level, sampled only in IDLE
//   flush_ack_o           one-cycle pulse when the flush completes
//   busy_o                high whenever the sequencer is not idle
//   tag_req_o/tag_gnt_i   tag-array read of set_o; tag_valid_i/tag_dirty_i next cycle
//   set_o                 current set for tag read, writeback and clear
//   wb_req_o/wb_gnt_i     writeback of line (set_o, wb_way_o); wb_done_i on completion
//   clr_req_o/clr_gnt_i   set-state write; valid = clr_valid_o, dirty = 0
//   wb_count_o            lines written back in the current/most recent flush
module wb_dcache_flush_ctrl #(
  parameter int unsigned NumSets = 256,
  parameter int unsigned NumWays = 8,
  parameter int unsigned SetW    = $clog2(NumSets),
  parameter int unsigned WayW    = $clog2(NumWays),
  parameter int unsigned CntW    = 12
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               flush_req_i,
  output logic               flush_ack_o,
  output logic               busy_o,
  output logic               tag_req_o,
  input  logic               tag_gnt_i,
  input  logic [NumWays-1:0] tag_valid_i,
  input  logic [NumWays-1:0] tag_dirty_i,
  output logic [SetW-1:0]    set_o,
  output logic               wb_req_o,
  output logic [WayW-1:0]    wb_way_o,
  input  logic               wb_gnt_i,
  input  logic               wb_done_i,
  output logic               clr_req_o,
  output logic [NumWays-1:0] clr_valid_o,
  input  logic               clr_gnt_i,
  output logic [CntW-1:0]    wb_count_o
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    READ    = 3'd1,
    WAIT    = 3'd2,
    SCAN    = 3'd3,
    WB      = 3'd4,
    WB_WAIT = 3'd5,
    CLEAR   = 3'd6,
    DONE    = 3'd7
  } state_t;

  state_t             state;
  logic [NumWays-1:0] pending;

  // Index of the lowest set bit; lowest way is written back first.
  function automatic logic [WayW-1:0] lowest_way(input logic [NumWays-1:0] mask);
    lowest_way = '0;
    for (int i = int'(NumWays) - 1; i >= 0; i--) begin
      if (mask[i]) lowest_way = WayW'(i);
    end
  endfunction

  // Sequencer; request/busy/ack outputs are set on entry to the state that owns them,
  // so no grant input reaches a request output combinationally.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      pending     <= '0;
      flush_ack_o <= 1'b0;
      busy_o      <= 1'b0;
      tag_req_o   <= 1'b0;
      wb_req_o    <= 1'b0;
      clr_req_o   <= 1'b0;
      set_o       <= '0;
      wb_way_o    <= '0;
      clr_valid_o <= '0;
      wb_count_o  <= '0;
    end else begin
      flush_ack_o <= 1'b0;
      case (state)
        IDLE: begin
          if (flush_req_i) begin
            set_o      <= '0;
            wb_count_o <= '0;
            busy_o     <= 1'b1;
            tag_req_o  <= 1'b1;
            state      <= READ;
          end
        end

        READ: begin
          if (tag_gnt_i) begin
            tag_req_o <= 1'b0;
            state     <= WAIT;
          end
        end

        // Tag data is valid the cycle after the grant.
        WAIT: begin
          pending <= tag_valid_i & tag_dirty_i;
`ifdef WB_FLUSH_INVALIDATE_EN
          clr_valid_o <= '0;
`else
          clr_valid_o <= tag_valid_i;
`endif
          state <= SCAN;
        end

        SCAN: begin
          if (pending != '0) begin
            wb_way_o <= lowest_way(pending);
            wb_req_o <= 1'b1;
            state    <= WB;
          end else begin
            clr_req_o <= 1'b1;
            state     <= CLEAR;
          end
        end

        WB: begin
          if (wb_gnt_i) begin
            wb_req_o <= 1'b0;
            state    <= WB_WAIT;
          end
        end

        // Only one writeback is ever in flight; done is honoured only here.
        WB_WAIT: begin
          if (wb_done_i) begin
            pending[wb_way_o] <= 1'b0;
            if (wb_count_o != {CntW{1'b1}}) begin
              wb_count_o <= wb_count_o + CntW'(1);
            end
            state <= SCAN;
          end
        end

        CLEAR: begin
          if (clr_gnt_i) begin
            clr_req_o <= 1'b0;
            if (set_o == SetW'(NumSets - 1)) begin
              flush_ack_o <= 1'b1;
              state       <= DONE;
            end else begin
              set_o     <= set_o + SetW'(1);
              tag_req_o <= 1'b1;
              state     <= READ;
            end
          end
        end

        DONE: begin
          busy_o <= 1'b0;
          state  <= IDLE;
        end

        default: begin
          busy_o    <= 1'b0;
          tag_req_o <= 1'b0;
          wb_req_o  <= 1'b0;
          clr_req_o <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_dcache_flush_ctrl.sv
// Directed bench for wb_dcache_flush_ctrl at default parameters. A single task
// drives one flush, plays the tag/writeback/clear responders each falling edge
// and records handshakes; expected values are hand-computed cycle counts.
module tb_wb_dcache_flush_ctrl;

  localparam int unsigned NumSets = 256;
  localparam int unsigned NumWays = 8;
  localparam int unsigned SetW    = 8;
  localparam int unsigned WayW    = 3;
  localparam int unsigned CntW    = 12;

`ifdef WB_FLUSH_INVALIDATE_EN
  localparam bit Inv = 1'b1;
`else
  localparam bit Inv = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst_i;
  logic               flush_req_i;
  logic               flush_ack_o;
  logic               busy_o;
  logic               tag_req_o;
  logic               tag_gnt_i;
  logic [NumWays-1:0] tag_valid_i;
  logic [NumWays-1:0] tag_dirty_i;
  logic [SetW-1:0]    set_o;
  logic               wb_req_o;
  logic [WayW-1:0]    wb_way_o;
  logic               wb_gnt_i;
  logic               wb_done_i;
  logic               clr_req_o;
  logic [NumWays-1:0] clr_valid_o;
  logic               clr_gnt_i;
  logic [CntW-1:0]    wb_count_o;

  logic [NumWays-1:0] vmem [NumSets];
  logic [NumWays-1:0] dmem [NumSets];

  assign tag_valid_i = vmem[set_o];
  assign tag_dirty_i = dmem[set_o];

  always #5 clk = ~clk;

  wb_dcache_flush_ctrl #(
    .NumSets(NumSets), .NumWays(NumWays), .SetW(SetW), .WayW(WayW), .CntW(CntW)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .flush_req_i(flush_req_i),
    .flush_ack_o(flush_ack_o),
    .busy_o     (busy_o),
    .tag_req_o  (tag_req_o),
    .tag_gnt_i  (tag_gnt_i),
    .tag_valid_i(tag_valid_i),
    .tag_dirty_i(tag_dirty_i),
    .set_o      (set_o),
    .wb_req_o   (wb_req_o),
    .wb_way_o   (wb_way_o),
    .wb_gnt_i   (wb_gnt_i),
    .wb_done_i  (wb_done_i),
    .clr_req_o  (clr_req_o),
    .clr_valid_o(clr_valid_o),
    .clr_gnt_i  (clr_gnt_i),
    .wb_count_o (wb_count_o)
  );

  int vectors    = 0;
  int miscompares = 0;

  // Per-flush observations
  int   ack_cnt, clr_cnt, order_err, way_err, ovl_err;
  int   wb_log[$];
  logic [NumWays-1:0] clr5, clr7;
  logic [SetW-1:0]    first_set;
  logic               first_busy;
  logic [CntW-1:0]    first_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_mem();
    for (int s = 0; s < int'(NumSets); s++) begin
      vmem[s] = '0;
      dmem[s] = '0;
    end
  endtask

  // Runs one flush starting at a falling edge (cycle 0). Cycle n is the n-th
  // following falling edge. Returns the cycle the ack is seen, or -1.
  // rst_set >= 0: assert reset mid-WB_WAIT of that set and return immediately.
  task automatic run_flush(input int drop_at, input int gnt_dly, input int done_dly,
                           input int spur_a, input int spur_b, input int rst_set,
                           output int ack_cyc);
    int gcnt = 0;
    int dcnt = 0;
    bit in_flight = 1'b0;
    bit was_req = 1'b0;
    logic [WayW-1:0] held_way = '0;
    ack_cyc = -1;
    ack_cnt = 0; clr_cnt = 0; order_err = 0; way_err = 0; ovl_err = 0;
    wb_log.delete();
    clr5 = 'x; clr7 = 'x;
    flush_req_i = 1'b1;
    for (int n = 1; n <= 3000; n++) begin
      @(negedge clk);
      if (n == drop_at) flush_req_i = 1'b0;
      if (n == 1) begin
        first_set  = set_o;
        first_busy = busy_o;
        first_cnt  = wb_count_o;
      end
      // writeback completion
      wb_done_i = 1'b0;
      if (in_flight) begin
        if (rst_set >= 0 && int'(set_o) == rst_set && dcnt == 2) begin
          rst_i = 1'b1;
          wb_gnt_i = 1'b0;
          return;
        end
        if (dcnt == done_dly) begin
          wb_done_i = 1'b1;
          in_flight = 1'b0;
        end else begin
          dcnt++;
        end
      end
      if (n == spur_a || n == spur_b) wb_done_i = 1'b1;
      // writeback grant and stability tracking
      if (wb_req_o) begin
        if (was_req && wb_way_o != held_way) way_err++;
        if (in_flight) ovl_err++;
        held_way = wb_way_o;
        was_req  = 1'b1;
        if (gcnt >= gnt_dly) begin
          wb_gnt_i = 1'b1;
        end else begin
          wb_gnt_i = 1'b0;
          gcnt++;
        end
        if (wb_gnt_i) begin
          in_flight = 1'b1;
          dcnt = 0;
          gcnt = 0;
          was_req = 1'b0;
          wb_log.push_back(int'(set_o) * 16 + int'(wb_way_o));
        end
      end else begin
        wb_gnt_i = 1'b0;
        gcnt = 0;
        was_req = 1'b0;
      end
      // clear handshakes must walk the sets in order
      if (clr_req_o && clr_gnt_i) begin
        if (set_o != SetW'(clr_cnt)) order_err++;
        if (set_o == SetW'(5)) clr5 = clr_valid_o;
        if (set_o == SetW'(7)) clr7 = clr_valid_o;
        clr_cnt++;
      end
      if (flush_ack_o) begin
        ack_cnt++;
        if (ack_cyc < 0) ack_cyc = n;
      end
      if (ack_cyc > 0 && n >= ack_cyc + 3) break;
    end
  endtask

  int ack;
  int late_acks;

  initial begin
    rst_i = 1'b1; flush_req_i = 1'b0;
    tag_gnt_i = 1'b1; clr_gnt_i = 1'b1; wb_gnt_i = 1'b0; wb_done_i = 1'b0;
    clear_mem();
    repeat (3) @(negedge clk);
    check("rst_busy",  32'(busy_o), 0);
    check("rst_reqs",  32'({tag_req_o, wb_req_o, clr_req_o, flush_ack_o}), 0);
    check("rst_set",   32'(set_o), 0);
    check("rst_count", 32'(wb_count_o), 0);
    rst_i = 1'b0;
    @(negedge clk);

    // Clean cache: 4 cycles per set, ack at 1 + 4*256
    run_flush(1, 0, 0, -1, -1, -1, ack);
    check("clean_ack_cyc",  32'(ack), 1025);
    check("clean_ack_cnt",  32'(ack_cnt), 1);
    check("clean_no_wb",    32'(wb_log.size()), 0);
    check("clean_clr_cnt",  32'(clr_cnt), 256);
    check("clean_order",    32'(order_err), 0);
    check("clean_first",    32'({first_busy, first_set}), 32'h100);
    check("clean_idle",     32'(busy_o), 0);
    check("clean_count",    32'(wb_count_o), 0);

    // Set 5: ways 1,6 valid+dirty, way 3 dirty only; set 7 valid A5 clean
    vmem[5] = 8'h42; dmem[5] = 8'h4A; vmem[7] = 8'hA5;
    run_flush(1, 0, 0, -1, -1, -1, ack);
    check("dirty_ack_cyc", 32'(ack), 1031);
    check("dirty_nwb",     32'(wb_log.size()), 2);
    if (wb_log.size() == 2) begin
      check("dirty_wb0", 32'(wb_log[0]), 5 * 16 + 1);
      check("dirty_wb1", 32'(wb_log[1]), 5 * 16 + 6);
    end
    check("dirty_count",   32'(wb_count_o), 2);
    check("dirty_clr5",    32'(clr5), Inv ? 0 : 32'h42);
    check("dirty_clr7",    32'(clr7), Inv ? 0 : 32'hA5);

    // Slow grant (10) and slow done (20): +11 WB, +21 WB_WAIT, +1 SCAN
    clear_mem();
    vmem[2] = 8'h01; dmem[2] = 8'h01;
    run_flush(1, 10, 20, -1, -1, -1, ack);
    check("slow_ack_cyc", 32'(ack), 1025 + 33);
    check("slow_way_stb", 32'(way_err), 0);
    check("slow_one_out", 32'(ovl_err), 0);
    check("slow_nwb",     32'(wb_log.size()), 1);
    check("slow_count",   32'(wb_count_o), 1);

    // Request dropped at 50; spurious done in both SCAN visits of set 3
    clear_mem();
    vmem[3] = 8'h04; dmem[3] = 8'h04;
    run_flush(50, 0, 0, 15, 18, -1, ack);
    check("spur_ack_cyc", 32'(ack), 1028);
    check("spur_ack_cnt", 32'(ack_cnt), 1);
    check("spur_count",   32'(wb_count_o), 1);
    if (wb_log.size() == 1) check("spur_wb0", 32'(wb_log[0]), 3 * 16 + 2);
    else check("spur_nwb", 32'(wb_log.size()), 1);

    // Reset during WB_WAIT of set 100
    clear_mem();
    vmem[5] = 8'h01; dmem[5] = 8'h01;
    vmem[100] = 8'h10; dmem[100] = 8'h10;
    run_flush(1, 0, 5, -1, -1, 100, ack);
    check("rstm_reached", 32'(rst_i), 1);
    @(negedge clk);
    check("rstm_flags",  32'({flush_ack_o, busy_o, tag_req_o, wb_req_o, clr_req_o}), 0);
    check("rstm_set",    32'(set_o), 0);
    check("rstm_way",    32'(wb_way_o), 0);
    check("rstm_valid",  32'(clr_valid_o), 0);
    check("rstm_count",  32'(wb_count_o), 0);
    rst_i = 1'b0; wb_done_i = 1'b0; flush_req_i = 1'b0;
    late_acks = 0;
    repeat (5) begin
      @(negedge clk);
      if (flush_ack_o || busy_o) late_acks++;
    end
    check("rstm_no_ack", 32'(late_acks), 0);
    vmem[100] = '0; dmem[100] = '0;
    run_flush(1, 0, 0, -1, -1, -1, ack);
    check("restart_first", 32'({first_busy, first_set}), 32'h100);
    check("restart_cnt0",  32'(first_cnt), 0);
    check("restart_ack",   32'(ack), 1028);
    check("restart_count", 32'(wb_count_o), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
